hex_scroll_ctrl: RTL and testbench
==================================

// Module: hex_scroll_ctrl
// PURPOSE
//  Sequencer for the four-digit 7-seg glyph rotation on HEX3..HEX0 (glyphs A,G,P,F).
//  Replaces the SW-selected rotation with a registered phase counter.
//  Phase advances automatically from a prescaled tick, or manually from a debounced step input.
//  Also provides blanking. Sits between board I/O (switches/keys) and the HEX pins.
// PARAMETERS
//  CLK_HZ   50_000_000  input clock frequency
//  STEP_HZ  2           auto-scroll rate; DIV = CLK_HZ/STEP_HZ (DIV >= 2)
// PORTS
//  CLOCK_50  in   1      system clock, rising edge
//  reset     in   1      synchronous, active-high
//  run       in   1      level; 1 = auto-scroll
//  dir       in   1      0 = phase +1 per advance, 1 = phase -1
//  step      in   1      asynchronous button, active-high; rising edge = one manual advance
//  blank     in   1      level; 1 = all digits off, sequencing frozen
//  HEX0..3   out  [0:6]  each; active-low segments, bit 0 = seg a; registered
//  phase     out  2      current rotation phase; registered
//  tick      out  1      one-cycle pulse on each auto advance
// BEHAVIOUR
//  Reset values (next edge with reset=1, from any state):
//   - phase=0, tick=0, prescaler=0, state=IDLE.
//   - HEX0=0001000 (A), HEX1=0100001 (G), HEX2=0011000 (P), HEX3=0111000 (F).
//   - step sync flops = 1.
//  Glyph index table: 0=A, 1=G, 2=P, 3=F. Blank code = 1111111.
//  Mapping: HEXi shows glyph ((i - phase) mod 4). All arithmetic is 2-bit, wrapping 3<->0.
//  HEX registers load from next-phase, so HEX and phase change on the same edge.
//  Step input path:
//   - 2-FF synchronizer, then a 3rd flop for edge detect (pulse = s2 & ~s3).
//   - Advance lands on the 3rd rising edge after step goes high.
//   - Held step gives exactly one advance; no debounce beyond sync, because the bench drives clean pulses.
//  FSM states: IDLE, RUN, BLANK.
//   - IDLE: prescaler held 0. A step pulse advances phase by 1 in dir.
//     Goes to RUN if run=1; goes to BLANK if blank=1.
//   - RUN: prescaler counts 0..DIV-1. At DIV-1: tick=1, prescaler wraps to 0, phase advances.
//     A step pulse advances phase and clears prescaler to 0.
//     Goes to IDLE if run=0 (prescaler cleared); goes to BLANK if blank=1.
//   - BLANK: all HEX=1111111. Phase frozen, prescaler 0, tick 0, step pulses ignored.
//     On blank=0: goes to RUN if run=1, else IDLE. HEX reloads the pattern for the held phase that edge.
//  Priority: reset > blank > step > tick.
//   - A step pulse and the tick in the same cycle give ONE advance; tick still pulses.
//  dir is sampled at the advance edge, so a dir change affects only later advances.
//  Reset mid-run: sequencing aborts and outputs return to reset values; no partial advance.
// STRUCTURE
//  hex_scroll_pkg:
//   - GLYPH_A/G/P/F and SEG_BLANK 7-bit constants.
//   - State encoding (IDLE=2'd0, RUN=2'd1, BLANK=2'd2).
//   - 2-bit glyph index type.
//  Sub-module hex_glyph_rom: 2-bit index -> 7-bit active-low segments, combinational.
//   - Four instances, one per digit.
//  Top holds prescaler ($clog2(DIV) bits), FSM, phase register, step synchronizer/edge detect, HEX output regs.
// TESTING (CLK_HZ=8, STEP_HZ=2 -> DIV=4)
//  1. reset 2 cycles -> HEX0..3 = 0001000/0100001/0011000/0111000, phase=0, tick=0.
//  2. run=1, dir=0 -> tick every 4th cycle; phase 0,1,2,3,0.
//     At phase=1: HEX0=0111000 (F), HEX1=0001000 (A).
//  3. run=1, dir=1 from phase 0 -> first tick gives phase=3 (HEX0=0100001 G), then 2.
//  4. run=0; step high 1 cycle -> phase 0->1 on 3rd edge.
//     step held 20 cycles -> exactly one advance.
//  5. run=1, blank=1 at phase 2 -> HEX all 1111111 next edge; phase stays 2 for 12 cycles, no tick.
//     blank=0 -> phase-2 pattern back; next tick 4 cycles later.
//  6. Step pulse aligned with tick -> phase +1 only.
//     reset asserted mid-run at phase 3 -> reset values next edge.

Source files
------------

// File: rtl/hex_scroll_pkg.sv
// Shared constants for the HEX3..HEX0 glyph rotation sequencer.
//   GLYPH_*   : active-low 7-seg codes, element 0 = segment a
//   SEG_BLANK : all segments off
//   ST_*      : sequencer state encoding
//   glyph_idx_t : 2-bit glyph index (0=A, 1=G, 2=P, 3=F)
package hex_scroll_pkg;

  typedef logic [1:0] glyph_idx_t;

  localparam logic [0:6] GLYPH_A   = 7'b0001000;
  localparam logic [0:6] GLYPH_G   = 7'b0100001;
  localparam logic [0:6] GLYPH_P   = 7'b0011000;
  localparam logic [0:6] GLYPH_F   = 7'b0111000;
  localparam logic [0:6] SEG_BLANK = 7'b1111111;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_BLANK = 2'd2;

endpackage

// File: rtl/hex_glyph_rom.sv
// Combinational glyph lookup: 2-bit glyph index to active-low segments.
//   idx : glyph index (0=A, 1=G, 2=P, 3=F)
//   seg : active-low segments, element 0 = segment a
module hex_glyph_rom
  import hex_scroll_pkg::*;
(
  input  glyph_idx_t idx,
  output logic [0:6] seg
);

  always_comb begin
    case (idx)
      2'd0:    seg = GLYPH_A;
      2'd1:    seg = GLYPH_G;
      2'd2:    seg = GLYPH_P;
      default: seg = GLYPH_F;
    endcase
  end

endmodule

// File: rtl/hex_scroll_ctrl.sv
// Sequencer for the four-digit A/G/P/F rotation on HEX3..HEX0.
// The phase advances from a prescaled tick (run=1) or from a synchronized
// rising edge of the step button; blank turns all digits off and freezes it.
//   CLOCK_50  : system clock        reset : synchronous, active-high
//   run       : 1 = auto-scroll     dir   : 0 = phase+1, 1 = phase-1
//   step      : async button        blank : 1 = digits off, frozen
//   HEX0..3   : registered active-low segments, element 0 = seg a
//   phase     : registered phase    tick  : one-cycle pulse per auto advance
//
// state    | meaning
// ST_IDLE  | no auto-scroll, prescaler held 0, step pulses advance
// ST_RUN   | prescaler counts 0..DIV-1, tick advances at DIV-1
// ST_BLANK | digits off, phase and prescaler frozen, steps ignored
module hex_scroll_ctrl
  import hex_scroll_pkg::*;
#(
  parameter int CLK_HZ  = 50_000_000,
  parameter int STEP_HZ = 2
) (
  input  logic       CLOCK_50,
  input  logic       reset,
  input  logic       run,
  input  logic       dir,
  input  logic       step,
  input  logic       blank,
  output logic [0:6] HEX0,
  output logic [0:6] HEX1,
  output logic [0:6] HEX2,
  output logic [0:6] HEX3,
  output logic [1:0] phase,
  output logic       tick
);

  localparam int DIV = CLK_HZ / STEP_HZ;
  localparam int PW  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);

  logic [1:0]    state, state_nxt;
  logic [PW-1:0] prescaler, pre_nxt;
  logic [1:0]    phase_nxt;
  logic          tick_nxt;
  logic          advance;
  logic          step_s1, step_s2, step_s3;
  logic          step_pulse;
  logic          hex_blank;
  glyph_idx_t    idx [4];
  logic [0:6]    seg [4];

  assign step_pulse = step_s2 & ~step_s3;

  always_comb begin
    state_nxt = state;
    pre_nxt   = '0;
    tick_nxt  = 1'b0;
    advance   = 1'b0;
    case (state)
      ST_BLANK: begin
        if (!blank) state_nxt = run ? ST_RUN : ST_IDLE;
      end
      ST_RUN: begin
        if (blank) begin
          state_nxt = ST_BLANK;
        end else if (!run) begin
          state_nxt = ST_IDLE;
          advance   = step_pulse;
        end else begin
          tick_nxt = (prescaler == PRE_LAST);
          // A coincident step and tick merge into one advance; both restart the count.
          advance  = step_pulse | tick_nxt;
          pre_nxt  = advance ? '0 : prescaler + PW'(1);
        end
      end
      default: begin
        if (blank) begin
          state_nxt = ST_BLANK;
        end else begin
          advance   = step_pulse;
          state_nxt = run ? ST_RUN : ST_IDLE;
        end
      end
    endcase
    phase_nxt = phase;
    if (advance) phase_nxt = dir ? phase - 2'd1 : phase + 2'd1;
  end

  assign hex_blank = (state_nxt == ST_BLANK);

  // Digits decode from next-phase so HEX and phase update on the same edge.
  for (genvar i = 0; i < 4; i++) begin : g_digit
    assign idx[i] = glyph_idx_t'(2'(i) - phase_nxt);
    hex_glyph_rom u_rom (
      .idx (idx[i]),
      .seg (seg[i])
    );
  end

  always_ff @(posedge CLOCK_50) begin
    if (reset) begin
      state     <= ST_IDLE;
      prescaler <= '0;
      phase     <= 2'd0;
      tick      <= 1'b0;
      step_s1   <= 1'b1;
      step_s2   <= 1'b1;
      step_s3   <= 1'b1;
      HEX0      <= GLYPH_A;
      HEX1      <= GLYPH_G;
      HEX2      <= GLYPH_P;
      HEX3      <= GLYPH_F;
    end else begin
      state     <= state_nxt;
      prescaler <= pre_nxt;
      phase     <= phase_nxt;
      tick      <= tick_nxt;
      step_s1   <= step;
      step_s2   <= step_s1;
      step_s3   <= step_s2;
      HEX0      <= hex_blank ? SEG_BLANK : seg[0];
      HEX1      <= hex_blank ? SEG_BLANK : seg[1];
      HEX2      <= hex_blank ? SEG_BLANK : seg[2];
      HEX3      <= hex_blank ? SEG_BLANK : seg[3];
    end
  end

endmodule

// File: tb/tb_hex_scroll_ctrl.sv
// Bench for hex_scroll_ctrl with CLK_HZ=8, STEP_HZ=2 (auto advance every 4 cycles).
module tb_hex_scroll_ctrl;

  localparam int DIV = 4;
  localparam int M_IDLE = 0, M_AUTO = 1, M_OFF = 2;

  logic       clk = 1'b0;
  logic       reset = 1'b1, run = 1'b0, dir = 1'b0, step = 1'b0, blank = 1'b0;
  logic [0:6] hex0, hex1, hex2, hex3;
  logic [1:0] phase;
  logic       tick;
  logic [0:6] dut_hex [4];
  logic [0:6] glyph_tab [4];

  int checks = 0;
  int errors = 0;
  bit chk_en = 1'b0;

  always #5 clk = ~clk;

  hex_scroll_ctrl #(.CLK_HZ(8), .STEP_HZ(2)) dut (
    .CLOCK_50 (clk),
    .reset    (reset),
    .run      (run),
    .dir      (dir),
    .step     (step),
    .blank    (blank),
    .HEX0     (hex0),
    .HEX1     (hex1),
    .HEX2     (hex2),
    .HEX3     (hex3),
    .phase    (phase),
    .tick     (tick)
  );

  assign dut_hex[0] = hex0;
  assign dut_hex[1] = hex1;
  assign dut_hex[2] = hex2;
  assign dut_hex[3] = hex3;

  initial begin
    glyph_tab[0] = 7'b0001000;
    glyph_tab[1] = 7'b0100001;
    glyph_tab[2] = 7'b0011000;
    glyph_tab[3] = 7'b0111000;
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: step history, mode, phase and auto-count as plain integers.
  int m_ph = 0, m_cnt = 0, m_mode = M_IDLE;
  bit m_tick = 1'b0;
  bit h1 = 1'b1, h2 = 1'b1, h3 = 1'b1;  // step sampled 1, 2, 3 edges ago

  always @(posedge clk) begin
    bit pulse;
    bit adv;
    pulse = h2 && !h3;
    adv   = 1'b0;
    if (reset) begin
      m_ph = 0; m_cnt = 0; m_mode = M_IDLE; m_tick = 1'b0;
      h1 = 1'b1; h2 = 1'b1; h3 = 1'b1;
    end else begin
      h3 = h2; h2 = h1; h1 = step;
      m_tick = 1'b0;
      if (m_mode == M_OFF) begin
        m_cnt = 0;
        if (!blank) m_mode = run ? M_AUTO : M_IDLE;
      end else if (blank) begin
        m_mode = M_OFF;
        m_cnt  = 0;
      end else if (m_mode == M_IDLE || !run) begin
        adv    = pulse;
        m_cnt  = 0;
        m_mode = run ? M_AUTO : M_IDLE;
      end else begin
        m_tick = (m_cnt == DIV - 1);
        adv    = pulse || m_tick;
        m_cnt  = adv ? 0 : m_cnt + 1;
      end
      if (adv) m_ph = (m_ph + (dir ? 3 : 1)) % 4;
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("phase", 32'(phase), 32'(m_ph));
      check("tick", 32'(tick), 32'(m_tick));
      for (int i = 0; i < 4; i++) begin
        check($sformatf("hex%0d", i), 32'(dut_hex[i]),
              32'((m_mode == M_OFF) ? 7'b1111111 : glyph_tab[(i - m_ph + 4) % 4]));
      end
    end
  end

  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!tick && n < limit);
    check("tick_wait", 32'(tick), 32'd1);
  endtask

  initial begin
    int n;
    int p;
    repeat (2) @(negedge clk);
    check("rst_hex0", 32'(hex0), 32'(7'b0001000));
    check("rst_hex1", 32'(hex1), 32'(7'b0100001));
    check("rst_hex2", 32'(hex2), 32'(7'b0011000));
    check("rst_hex3", 32'(hex3), 32'(7'b0111000));
    check("rst_phase", 32'(phase), 32'd0);
    check("rst_tick", 32'(tick), 32'd0);
    chk_en = 1'b1;

    reset = 1'b0; run = 1'b1; dir = 1'b0;
    wait_tick(10, n);
    check("first_tick_lat", 32'(n), 32'd5);
    check("up_phase1", 32'(phase), 32'd1);
    check("up_hex0_F", 32'(hex0), 32'(7'b0111000));
    check("up_hex1_A", 32'(hex1), 32'(7'b0001000));
    wait_tick(10, n);
    check("tick_period", 32'(n), 32'd4);
    check("up_phase2", 32'(phase), 32'd2);
    wait_tick(10, n);
    check("up_phase3", 32'(phase), 32'd3);
    wait_tick(10, n);
    check("up_wrap0", 32'(phase), 32'd0);

    dir = 1'b1;
    wait_tick(10, n);
    check("down_phase3", 32'(phase), 32'd3);
    check("down_hex0_G", 32'(hex0), 32'(7'b0100001));
    wait_tick(10, n);
    check("down_phase2", 32'(phase), 32'd2);

    blank = 1'b1;
    @(negedge clk);
    check("blank_hex0", 32'(hex0), 32'(7'b1111111));
    check("blank_hex3", 32'(hex3), 32'(7'b1111111));
    repeat (12) @(negedge clk);
    check("blank_hold", 32'(phase), 32'd2);
    blank = 1'b0;
    @(negedge clk);
    check("unblank_hex0_P", 32'(hex0), 32'(7'b0011000));
    check("unblank_hex2_A", 32'(hex2), 32'(7'b0001000));
    wait_tick(10, n);
    check("unblank_tick_lat", 32'(n), 32'd4);
    check("unblank_phase", 32'(phase), 32'd1);

    run = 1'b0; dir = 1'b0;
    @(negedge clk);
    p = int'(phase);
    step = 1'b1;
    @(negedge clk);
    check("step_e1", 32'(phase), 32'(p));
    step = 1'b0;
    @(negedge clk);
    check("step_e2", 32'(phase), 32'(p));
    @(negedge clk);
    check("step_e3", 32'(phase), 32'((p + 1) % 4));
    repeat (3) @(negedge clk);
    step = 1'b1;
    repeat (20) @(negedge clk);
    step = 1'b0;
    repeat (4) @(negedge clk);
    check("step_held_once", 32'(phase), 32'((p + 2) % 4));

    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 19) == 0) run = ~run;
      if ($urandom_range(0, 9) == 0) dir = ~dir;
      if ($urandom_range(0, 29) == 0) blank = ~blank;
      if ($urandom_range(0, 5) == 0) step = ~step;
      reset = ($urandom_range(0, 299) == 0);
      @(negedge clk);
    end

    reset = 1'b0; blank = 1'b0; run = 1'b1; dir = 1'b0; step = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (phase != 2'd3 && n < 40);
    check("reach_phase3", 32'(phase), 32'd3);
    reset = 1'b1;
    @(negedge clk);
    check("midrun_rst_phase", 32'(phase), 32'd0);
    check("midrun_rst_hex0", 32'(hex0), 32'(7'b0001000));
    check("midrun_rst_tick", 32'(tick), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
